pcg_loader: RTL and testbench
=============================

PCG_LOADER -- requirements
Module: pcg_loader

Interface
REQ-001 SHALL have parameters: ADDR_W, default 11, CG address width; IO_BASE, default 8'h00, 8-aligned Z80 I/O base.
REQ-002 SHALL have ports (name, direction, width, meaning):
- i_CLK, in, 1, sole clock.
- i_RST, in, 1, reset (synchronous, active-high).
- i_nIORQ, i_nRD, i_nWR, in, 1 each, Z80 strobes.
- i_ZA, in, 8, Z80 address.
- i_ZD, in, 8, Z80 write data.
- o_ZD, out, 8, Z80 read data.
- o_ZD_OE, out, 1, read-data enable.
- i_FA, in, ADDR_W, display font address.
- i_CD, in, 8, ROM read data.
- o_CA, out, ADDR_W, CG address.
- o_CD, out, 8, RAM write data.
- o_CD_OE, out, 1, RAM write-data enable.
- o_nRAM_CS, o_nRAM_WR, o_nROM_CS, out, 1 each, active-low memory strobes.
- o_BUSY, out, 1, engine active.

Function
REQ-003 SHALL decode register window IO_BASE+0..6: 0 DATA(W); 1 ADDR_LO(R/W); 2 ADDR_HI(R/W, low ADDR_W-8 bits); 3 CTRL(W); 4 COUNT(R/W, 0 means 256); 6 STATUS(R). Offsets 5 and 7 SHALL be ignored.
REQ-004 SHALL register each I/O write exactly once per access: rising edge of the decoded !i_nIORQ & !i_nWR, sampled on i_CLK.
REQ-005 SHALL define CTRL bits: [0] AINC; [1] FULL (all-RAM, 2^ADDR_W chars); [2] PCG_EN; [6] ABORT (self-clearing); [7] GO (self-clearing).
REQ-006 SHALL define STATUS bits: [0] BUSY; [1] OVR (sticky).
REQ-007 SHALL run an FSM with states IDLE, WR_SETUP, WR_PULSE, WR_HOLD, CP_RD, CP_LATCH, CP_WR, CP_NEXT.
REQ-008 SHALL, on a DATA write in IDLE, latch the data and run WR_SETUP->WR_PULSE->WR_HOLD->IDLE (3 cycles).
- o_CA = ADDR throughout.
- o_CD_OE=1 throughout.
- o_nRAM_CS=0 throughout.
- o_nRAM_WR=0 in WR_PULSE only.
- At exit, ADDR+=1 if AINC.
REQ-009 SHALL, on GO in IDLE, copy COUNT bytes from ROM to RAM at the same address, 4 cycles per byte:
- CP_RD: o_nROM_CS=0, o_CA=ADDR.
- CP_LATCH: i_CD latched.
- CP_WR: RAM strobes as in WR_PULSE.
- CP_NEXT: ADDR+=1, COUNT-=1; then IDLE if COUNT reaches 0 or ABORT is pending, else CP_RD.
REQ-010 SHALL wrap ADDR modulo 2^ADDR_W; COUNT SHALL be left at 0 after normal completion.
REQ-011 SHALL, while BUSY, ignore writes to DATA/ADDR/COUNT and GO and set OVR. Writes to CTRL bits [2:0] and ABORT SHALL be accepted. Any CTRL write SHALL clear OVR, except when that same write sets OVR.
REQ-012 SHALL act on ABORT in copy only after the current byte's CP_WR completes; ABORT in IDLE or a single write SHALL be a no-op.
REQ-013 SHALL, in IDLE, present display fetch:
- o_CA=i_FA.
- RAM selected when PCG_EN & (FULL | i_FA[ADDR_W-1]), else ROM selected.
- o_nRAM_WR=1.
REQ-014 SHALL drive o_ZD_OE=1 combinationally during !i_nIORQ & !i_nRD to readable offsets only; o_ZD=0 otherwise.
REQ-015 SHALL assert o_BUSY in all non-IDLE states; GO and DATA arriving on the same edge SHALL give GO priority, and the DATA write SHALL set OVR.

Reset
REQ-016 SHALL, when i_RST=1 at i_CLK, set FSM=IDLE and clear ADDR, COUNT, CTRL, OVR and latched data to 0. This SHALL include mid-copy reset, with no further strobes.
REQ-017 SHALL hold outputs during reset: o_nRAM_CS, o_nRAM_WR and o_nROM_CS =1 (PCG_EN=0 selects ROM off-reset only after release), o_CD_OE=0, o_ZD_OE per REQ-014, o_BUSY=0.

Structure
REQ-018 SHALL place register offsets, CTRL/STATUS bit positions and the FSM state enum in shared package pcg_pkg.
REQ-019 SHALL implement bus decode and write-edge detection as sub-module pcg_io_decode; the FSM and datapath SHALL remain in pcg_loader.

Verification
REQ-020 Single write with AINC=1: ADDR=0x123 and DATA=0x5A -> one RAM write of 0x5A at 0x123, a one-cycle o_nRAM_WR pulse, and ADDR reads back 0x124.
REQ-021 Copy: ADDR=0x7FE, COUNT=4 and ROM pattern = address low byte -> RAM written at 0x7FE, 0x7FF, 0x000, 0x001; o_BUSY high for 16 cycles; COUNT reads 0.
REQ-022 COUNT=0 with GO -> 256 bytes copied and o_BUSY high for 1024 cycles.
REQ-023 ABORT during byte 3 of a 10-byte copy -> exactly 3 RAM writes, then IDLE. DATA write while busy -> ignored and OVR=1; the next CTRL write clears OVR.
REQ-024 Display fetch with PCG_EN=1, FULL=0 -> i_FA=0x3FF selects ROM and i_FA=0x400 selects RAM. With FULL=1 -> both select RAM.
REQ-025 i_RST asserted mid-copy -> on the next edge all strobes go high, o_BUSY=0, and registers read 0.

Source files
------------

// File: rtl/pcg_pkg.sv
// Shared definitions for the PCG loader: register map, CTRL/STATUS bit
// positions and the loader FSM state encoding.
package pcg_pkg;

  // Register offsets inside the 8-byte I/O window
  localparam logic [2:0] OFF_DATA    = 3'd0;
  localparam logic [2:0] OFF_ADDR_LO = 3'd1;
  localparam logic [2:0] OFF_ADDR_HI = 3'd2;
  localparam logic [2:0] OFF_CTRL    = 3'd3;
  localparam logic [2:0] OFF_COUNT   = 3'd4;
  localparam logic [2:0] OFF_STATUS  = 3'd6;

  // CTRL bit positions
  localparam int CTRL_AINC   = 0;
  localparam int CTRL_FULL   = 1;
  localparam int CTRL_PCG_EN = 2;
  localparam int CTRL_ABORT  = 6;
  localparam int CTRL_GO     = 7;

  // STATUS bit positions
  localparam int STAT_BUSY = 0;
  localparam int STAT_OVR  = 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    CP_RD,
    CP_LATCH,
    CP_WR,
    CP_NEXT
  } pcg_state_e;

  // Offsets that drive read data back onto the Z80 bus
  function automatic logic is_readable(input logic [2:0] off);
    return (off == OFF_ADDR_LO) || (off == OFF_ADDR_HI) ||
           (off == OFF_COUNT)   || (off == OFF_STATUS);
  endfunction

  // States belonging to a ROM-to-RAM copy
  function automatic logic is_copy(input pcg_state_e s);
    return (s == CP_RD) || (s == CP_LATCH) || (s == CP_WR) || (s == CP_NEXT);
  endfunction

endpackage

// File: rtl/pcg_io_decode.sv
// Z80 I/O window decode: register offset, one-shot write strobe per bus
// write cycle, and combinational read-enable for readable registers.
module pcg_io_decode
  import pcg_pkg::*;
#(
  parameter logic [7:0] IO_BASE = 8'h00
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_nIORQ,
  input  logic       i_nRD,
  input  logic       i_nWR,
  input  logic [7:0] i_ZA,
  output logic [2:0] o_OFF,
  output logic       o_WR_STB,
  output logic       o_RD_OE
);

  logic hit;
  logic wr_lvl;
  logic wr_lvl_q;

  // The window is 8-aligned, so only the upper five address bits select it
  assign hit    = (i_ZA[7:3] == IO_BASE[7:3]);
  assign o_OFF  = i_ZA[2:0];
  assign wr_lvl = hit & ~i_nIORQ & ~i_nWR;

  // Previous sample of the decoded write level, for rising-edge detection
  always_ff @(posedge i_CLK) begin
    if (i_RST) wr_lvl_q <= 1'b0;
    else       wr_lvl_q <= wr_lvl;
  end

  // A Z80 write spans several clocks; act only on its first sampled cycle
  assign o_WR_STB = wr_lvl & ~wr_lvl_q;
  assign o_RD_OE  = hit & ~i_nIORQ & ~i_nRD & is_readable(i_ZA[2:0]);

endmodule

// File: rtl/pcg_loader.sv
// PCG loader: Z80-programmable engine that writes single bytes or copies
// ROM font data into character-generator RAM, and arbitrates the CG bus
// for display fetch while idle. Supports ADDR_W from 9 to 16.
module pcg_loader
  import pcg_pkg::*;
#(
  parameter int         ADDR_W  = 11,
  parameter logic [7:0] IO_BASE = 8'h00
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_nIORQ,
  input  logic              i_nRD,
  input  logic              i_nWR,
  input  logic [7:0]        i_ZA,
  input  logic [7:0]        i_ZD,
  output logic [7:0]        o_ZD,
  output logic              o_ZD_OE,
  input  logic [ADDR_W-1:0] i_FA,
  input  logic [7:0]        i_CD,
  output logic [ADDR_W-1:0] o_CA,
  output logic [7:0]        o_CD,
  output logic              o_CD_OE,
  output logic              o_nRAM_CS,
  output logic              o_nRAM_WR,
  output logic              o_nROM_CS,
  output logic              o_BUSY
);

  localparam int HI_W = ADDR_W - 8;

  pcg_state_e        state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        count;
  logic [7:0]        wdata;
  logic              ainc, full, pcg_en;
  logic              ovr;
  logic              abort_pend;

  logic [2:0]        off;
  logic              wr_stb, rd_oe;
  logic              wr_data, wr_addr_lo, wr_addr_hi, wr_ctrl, wr_count;
  logic              busy, abort_now, disp_ram;
  logic [ADDR_W-1:0] ca;
  logic              nram_cs, nram_wr, nrom_cs, cd_oe;
  logic [7:0]        rd_data;

  pcg_io_decode #(
    .IO_BASE (IO_BASE)
  ) u_io_decode (
    .i_CLK    (i_CLK),
    .i_RST    (i_RST),
    .i_nIORQ  (i_nIORQ),
    .i_nRD    (i_nRD),
    .i_nWR    (i_nWR),
    .i_ZA     (i_ZA),
    .o_OFF    (off),
    .o_WR_STB (wr_stb),
    .o_RD_OE  (rd_oe)
  );

  assign wr_data    = wr_stb & (off == OFF_DATA);
  assign wr_addr_lo = wr_stb & (off == OFF_ADDR_LO);
  assign wr_addr_hi = wr_stb & (off == OFF_ADDR_HI);
  assign wr_ctrl    = wr_stb & (off == OFF_CTRL);
  assign wr_count   = wr_stb & (off == OFF_COUNT);

  assign busy      = (state != IDLE);
  // An ABORT landing on the CP_NEXT edge itself still stops after this byte
  assign abort_now = abort_pend | (wr_ctrl & i_ZD[CTRL_ABORT]);
  // Upper half of the CG space is RAM; FULL maps every character to RAM
  assign disp_ram  = pcg_en & (full | i_FA[ADDR_W-1]);

  // Next-state and CG bus strobes; reset forces every strobe inactive
  always_comb begin
    state_nx = state;
    ca       = addr;
    nram_cs  = 1'b1;
    nram_wr  = 1'b1;
    nrom_cs  = 1'b1;
    cd_oe    = 1'b0;
    case (state)
      IDLE: begin
        ca      = i_FA;
        nram_cs = ~disp_ram;
        nrom_cs = disp_ram;
        // Only one register is addressed per bus cycle, so GO can never
        // coincide with a DATA write; GO is tested first regardless
        if (wr_ctrl && i_ZD[CTRL_GO]) state_nx = CP_RD;
        else if (wr_data)             state_nx = WR_SETUP;
      end
      WR_SETUP: begin
        nram_cs  = 1'b0;
        cd_oe    = 1'b1;
        state_nx = WR_PULSE;
      end
      WR_PULSE: begin
        nram_cs  = 1'b0;
        nram_wr  = 1'b0;
        cd_oe    = 1'b1;
        state_nx = WR_HOLD;
      end
      WR_HOLD: begin
        nram_cs  = 1'b0;
        cd_oe    = 1'b1;
        state_nx = IDLE;
      end
      CP_RD: begin
        nrom_cs  = 1'b0;
        state_nx = CP_LATCH;
      end
      CP_LATCH: begin
        // ROM stays selected so i_CD is valid at the latching edge
        nrom_cs  = 1'b0;
        state_nx = CP_WR;
      end
      CP_WR: begin
        nram_cs  = 1'b0;
        nram_wr  = 1'b0;
        cd_oe    = 1'b1;
        state_nx = CP_NEXT;
      end
      CP_NEXT: begin
        state_nx = ((count == 8'd1) || abort_now) ? IDLE : CP_RD;
      end
      default: state_nx = IDLE;
    endcase
    if (i_RST) begin
      nram_cs = 1'b1;
      nram_wr = 1'b1;
      nrom_cs = 1'b1;
      cd_oe   = 1'b0;
    end
  end

  // FSM state, programming registers and the byte datapath
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state      <= IDLE;
      addr       <= '0;
      count      <= '0;
      wdata      <= '0;
      ainc       <= 1'b0;
      full       <= 1'b0;
      pcg_en     <= 1'b0;
      ovr        <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      state <= state_nx;

      // Host writes; address/count/data are frozen while the engine runs
      if (!busy) begin
        if (wr_addr_lo) addr[7:0]        <= i_ZD;
        if (wr_addr_hi) addr[ADDR_W-1:8] <= i_ZD[HI_W-1:0];
        if (wr_count)   count            <= i_ZD;
        if (wr_data)    wdata            <= i_ZD;
      end
      if (wr_ctrl) begin
        ainc   <= i_ZD[CTRL_AINC];
        full   <= i_ZD[CTRL_FULL];
        pcg_en <= i_ZD[CTRL_PCG_EN];
      end

      // OVR flags any rejected host access; a CTRL write clears it unless
      // that write is itself a rejected GO
      if (busy && (wr_data || wr_addr_lo || wr_addr_hi || wr_count))
        ovr <= 1'b1;
      else if (wr_ctrl)
        ovr <= busy & i_ZD[CTRL_GO];

      if (state_nx == IDLE)
        abort_pend <= 1'b0;
      else if (wr_ctrl && i_ZD[CTRL_ABORT] && is_copy(state))
        abort_pend <= 1'b1;

      case (state)
        WR_HOLD:  if (ainc) addr <= addr + 1'b1;
        CP_LATCH: wdata <= i_CD;
        CP_NEXT: begin
          addr  <= addr + 1'b1;
          count <= count - 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Register read-back mux; data bus is zero whenever not enabled
  always_comb begin
    rd_data = '0;
    if (rd_oe) begin
      case (off)
        OFF_ADDR_LO: rd_data = addr[7:0];
        OFF_ADDR_HI: rd_data = 8'(addr[ADDR_W-1:8]);
        OFF_COUNT:   rd_data = count;
        OFF_STATUS: begin
          rd_data[STAT_BUSY] = busy & ~i_RST;
          rd_data[STAT_OVR]  = ovr;
        end
        default:     rd_data = '0;
      endcase
    end
  end

  assign o_ZD      = rd_data;
  assign o_ZD_OE   = rd_oe;
  assign o_CA      = ca;
  assign o_CD      = wdata;
  assign o_CD_OE   = cd_oe;
  assign o_nRAM_CS = nram_cs;
  assign o_nRAM_WR = nram_wr;
  assign o_nROM_CS = nrom_cs;
  assign o_BUSY    = busy & ~i_RST;

endmodule

// File: tb/tb_pcg_loader.sv
// Self-checking bench for pcg_loader: randomized single writes and copies
// compared against a queue-based model of expected RAM writes.
module tb_pcg_loader;
  import pcg_pkg::*;

  localparam int         AW   = 11;
  localparam int         MASK = (1 << AW) - 1;
  localparam logic [7:0] BASE = 8'h40;

  logic          clk = 1'b0;
  logic          rst, niorq, nrd, nwr;
  logic [7:0]    za, zd_in, zd_out, cd_in, cd_out;
  logic          zd_oe, cd_oe, nram_cs, nram_wr, nrom_cs, busy;
  logic [AW-1:0] fa, ca;
  logic [7:0]    key;

  int n_cmp, n_err;
  int obs_a[$], obs_d[$];
  int exp_a[$], exp_d[$];
  int obs_base;
  int busy_total;
  int m_addr, m_count;
  logic [2:0] m_ctrl;

  always #5 clk = ~clk;

  // ROM content: address low byte scrambled by a per-test key
  assign cd_in = ca[7:0] ^ key;

  pcg_loader #(
    .ADDR_W  (AW),
    .IO_BASE (BASE)
  ) dut (
    .i_CLK     (clk),
    .i_RST     (rst),
    .i_nIORQ   (niorq),
    .i_nRD     (nrd),
    .i_nWR     (nwr),
    .i_ZA      (za),
    .i_ZD      (zd_in),
    .o_ZD      (zd_out),
    .o_ZD_OE   (zd_oe),
    .i_FA      (fa),
    .i_CD      (cd_in),
    .o_CA      (ca),
    .o_CD      (cd_out),
    .o_CD_OE   (cd_oe),
    .o_nRAM_CS (nram_cs),
    .o_nRAM_WR (nram_wr),
    .o_nROM_CS (nrom_cs),
    .o_BUSY    (busy)
  );

  // RAM write and busy-cycle monitor
  always @(negedge clk) begin
    if (!nram_cs && !nram_wr && cd_oe) begin
      obs_a.push_back(int'(ca));
      obs_d.push_back(int'(cd_out));
    end
    if (busy) busy_total++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic io_wr_raw(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    za = a; zd_in = d; niorq = 1'b0; nwr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    niorq = 1'b1; nwr = 1'b1;
  endtask

  task automatic io_wr(input logic [2:0] off, input logic [7:0] d);
    io_wr_raw(BASE | {5'd0, off}, d);
  endtask

  task automatic io_rd(input logic [2:0] off, output logic [7:0] d, output logic oe);
    @(negedge clk);
    za = BASE | {5'd0, off}; niorq = 1'b0; nrd = 1'b0;
    #1;
    d = zd_out; oe = zd_oe;
    #1;
    niorq = 1'b1; nrd = 1'b1;
  endtask

  task automatic chk_rd(input string tag, input logic [2:0] off, input int exp);
    logic [7:0] d;
    logic oe;
    io_rd(off, d, oe);
    chk(tag, d, exp);
    chk({tag, "_oe"}, oe, 1);
  endtask

  task automatic chk_regs(input string tag);
    chk_rd({tag, "_alo"}, OFF_ADDR_LO, m_addr & 8'hFF);
    chk_rd({tag, "_ahi"}, OFF_ADDR_HI, m_addr >> 8);
    chk_rd({tag, "_cnt"}, OFF_COUNT, m_count);
  endtask

  task automatic set_ctrl(input logic [2:0] v);
    io_wr(OFF_CTRL, {5'd0, v});
    m_ctrl = v;
  endtask

  task automatic set_addr(input int a);
    io_wr(OFF_ADDR_LO, 8'(a));
    io_wr(OFF_ADDR_HI, 8'(a >> 8));
    m_addr = a & MASK;
  endtask

  task automatic set_count(input int n);
    io_wr(OFF_COUNT, 8'(n));
    m_count = n & 8'hFF;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (busy && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("idle_timeout", busy, 0);
    @(negedge clk);
  endtask

  task automatic check_writes(input string tag);
    int n;
    n = obs_a.size() - obs_base;
    chk({tag, "_nwr"}, n, exp_a.size());
    for (int i = 0; i < exp_a.size() && i < n; i++) begin
      chk({tag, "_wa"}, obs_a[obs_base + i], exp_a[i]);
      chk({tag, "_wd"}, obs_d[obs_base + i], exp_d[i]);
    end
    obs_base = obs_a.size();
    exp_a.delete();
    exp_d.delete();
  endtask

  task automatic do_single(input logic [7:0] d);
    int b0;
    b0 = busy_total;
    exp_a.push_back(m_addr);
    exp_d.push_back(int'(d));
    io_wr(OFF_DATA, d);
    wait_idle(20);
    chk("wr_busy", busy_total - b0, 3);
    if (m_ctrl[CTRL_AINC]) m_addr = (m_addr + 1) & MASK;
    check_writes("wr");
    chk_regs("wr");
  endtask

  task automatic do_copy(input int a, input int n);
    int b0, aa;
    set_addr(a);
    set_count(n);
    for (int i = 0; i < n; i++) begin
      aa = (a + i) & MASK;
      exp_a.push_back(aa);
      exp_d.push_back((aa & 8'hFF) ^ int'(key));
    end
    b0 = busy_total;
    io_wr(OFF_CTRL, {1'b1, 4'd0, m_ctrl});
    wait_idle(4 * n + 20);
    chk("cp_busy", busy_total - b0, 4 * n);
    m_addr  = (a + n) & MASK;
    m_count = 0;
    check_writes("cp");
    chk_regs("cp");
  endtask

  initial begin
    int b0, a, n, snap, exp_ram;
    logic [7:0] d;
    logic oe;
    rst = 1'b1; niorq = 1'b1; nrd = 1'b1; nwr = 1'b1;
    za = 8'h00; zd_in = 8'h00; fa = '0; key = 8'h00;
    m_addr = 0; m_count = 0; m_ctrl = 3'd0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_nram_cs", nram_cs, 1);
    chk("rst_nram_wr", nram_wr, 1);
    chk("rst_nrom_cs", nrom_cs, 1);
    chk("rst_cd_oe", cd_oe, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_rom_sel", nrom_cs, 0);
    chk_regs("rst");
    chk_rd("rst_stat", OFF_STATUS, 0);
    io_rd(OFF_DATA, d, oe);
    chk("data_rd_oe", oe, 0);
    chk("data_rd_zd", d, 0);

    // Ignored accesses: offsets 5/7 and a write outside the window
    b0 = busy_total;
    io_wr(3'd5, 8'hFF);
    io_wr(3'd7, 8'hFF);
    io_wr_raw(8'h48, 8'hA5);
    repeat (4) @(negedge clk);
    chk("ign_busy", busy_total - b0, 0);
    check_writes("ign");

    // Single write with auto-increment at 0x123
    set_ctrl(3'b001);
    set_addr(12'h123);
    do_single(8'h5A);

    // Randomized single writes
    for (int i = 0; i < 6; i++) begin
      set_ctrl(3'($urandom_range(0, 1)));
      set_addr(int'($urandom_range(0, MASK)));
      do_single(8'($urandom));
    end

    // Copy across the address wrap with ROM = address low byte
    key = 8'h00;
    set_ctrl(3'b000);
    do_copy(12'h7FE, 4);

    // COUNT=0 means 256 bytes
    key = 8'($urandom);
    do_copy(int'($urandom_range(0, MASK)), 256);

    // Randomized copies
    for (int i = 0; i < 3; i++) begin
      key = 8'($urandom);
      do_copy(int'($urandom_range(0, MASK)), int'($urandom_range(1, 20)));
    end

    // ABORT during byte 3 of a 10-byte copy
    key = 8'h3C;
    a = int'($urandom_range(0, MASK));
    set_addr(a);
    set_count(10);
    b0 = busy_total;
    io_wr(OFF_CTRL, {1'b1, 4'd0, m_ctrl});
    for (int i = 0; i < 100 && (obs_a.size() - obs_base) < 2; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    io_wr(OFF_CTRL, {1'b0, 1'b1, 3'd0, m_ctrl});
    wait_idle(100);
    for (int i = 0; i < 3; i++) begin
      exp_a.push_back((a + i) & MASK);
      exp_d.push_back((((a + i) & MASK) & 8'hFF) ^ 8'h3C);
    end
    chk("abort_busy", busy_total - b0, 12);
    m_addr = (a + 3) & MASK;
    m_count = 7;
    check_writes("abort");
    chk_regs("abort");

    // DATA and ADDR writes while busy are dropped and raise OVR
    a = int'($urandom_range(0, MASK));
    set_addr(a);
    set_count(10);
    for (int i = 0; i < 10; i++) begin
      exp_a.push_back((a + i) & MASK);
      exp_d.push_back((((a + i) & MASK) & 8'hFF) ^ 8'h3C);
    end
    b0 = busy_total;
    io_wr(OFF_CTRL, {1'b1, 4'd0, m_ctrl});
    io_wr(OFF_DATA, 8'hEE);
    io_wr(OFF_ADDR_LO, 8'h55);
    chk_rd("ovr_stat_busy", OFF_STATUS, 3);
    wait_idle(100);
    chk("ovr_busy", busy_total - b0, 40);
    m_addr = (a + 10) & MASK;
    m_count = 0;
    check_writes("ovr");
    chk_regs("ovr");
    chk_rd("ovr_stat_idle", OFF_STATUS, 2);
    set_ctrl(m_ctrl);
    chk_rd("ovr_clr", OFF_STATUS, 0);

    // GO while busy sets OVR in the same CTRL write; a plain CTRL write clears it
    a = int'($urandom_range(0, MASK));
    set_addr(a);
    set_count(8);
    for (int i = 0; i < 8; i++) begin
      exp_a.push_back((a + i) & MASK);
      exp_d.push_back((((a + i) & MASK) & 8'hFF) ^ 8'h3C);
    end
    b0 = busy_total;
    io_wr(OFF_CTRL, {1'b1, 4'd0, m_ctrl});
    io_wr(OFF_CTRL, {1'b1, 4'd0, m_ctrl});
    chk_rd("go_busy_stat", OFF_STATUS, 3);
    io_wr(OFF_CTRL, {5'd0, m_ctrl});
    chk_rd("go_clr_stat", OFF_STATUS, 1);
    wait_idle(100);
    chk("go_busy_cyc", busy_total - b0, 32);
    m_addr = (a + 8) & MASK;
    m_count = 0;
    check_writes("gobusy");

    // Display fetch selection
    set_ctrl(3'b100);
    fa = 11'h3FF;
    #1;
    chk("disp_3ff_rom", nrom_cs, 0);
    chk("disp_3ff_ram", nram_cs, 1);
    fa = 11'h400;
    #1;
    chk("disp_400_rom", nrom_cs, 1);
    chk("disp_400_ram", nram_cs, 0);
    chk("disp_ca", ca, 11'h400);
    chk("disp_nwr", nram_wr, 1);
    set_ctrl(3'b110);
    fa = 11'h3FF;
    #1;
    chk("disp_full_3ff", nram_cs, 0);
    fa = 11'h400;
    #1;
    chk("disp_full_400", nram_cs, 0);
    for (int i = 0; i < 8; i++) begin
      set_ctrl(3'($urandom_range(0, 7)));
      fa = AW'($urandom_range(0, MASK));
      #1;
      exp_ram = (m_ctrl[CTRL_PCG_EN] && (m_ctrl[CTRL_FULL] || fa >= 11'h400)) ? 1 : 0;
      chk("disp_rnd_ram", nram_cs, exp_ram ? 0 : 1);
      chk("disp_rnd_rom", nrom_cs, exp_ram ? 1 : 0);
      chk("disp_rnd_ca", ca, fa);
    end

    // Reset in the middle of a copy
    set_ctrl(3'b001);
    set_addr(int'($urandom_range(0, MASK)));
    set_count(20);
    io_wr(OFF_CTRL, {1'b1, 4'd0, m_ctrl});
    io_wr(OFF_DATA, 8'h11);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_nram_cs", nram_cs, 1);
    chk("mid_rst_nrom_cs", nrom_cs, 1);
    @(negedge clk);
    snap = obs_a.size();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_nram_wr", nram_wr, 1);
    chk("mid_rst_cd_oe", cd_oe, 0);
    m_addr = 0; m_count = 0; m_ctrl = 3'd0;
    chk_rd("mid_rst_stat", OFF_STATUS, 0);
    rst = 1'b0;
    chk_regs("mid_rst");
    repeat (20) @(negedge clk);
    chk("mid_rst_no_wr", obs_a.size() - snap, 0);
    chk("mid_rst_idle", busy, 0);
    obs_base = obs_a.size();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
